// File: rtl/dnn_pkg.sv
// Shared types and arithmetic helpers for the parallel dense layer.
package dnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Tag fields are sized generously so one struct serves every
    // (N, M/LANES) configuration up to 64K inputs / groups.
    localparam int TAG_FIELD_W = 16;

    typedef struct packed {
        logic                   valid;
        logic                   is_bias;
        logic [TAG_FIELD_W-1:0] idx;
        logic [TAG_FIELD_W-1:0] grp;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // Offset-binary decode: inverting the MSB is the same as subtracting
    // 2^(w-1) from the raw code, which works for any width w < 32.
    function automatic logic signed [31:0] wt_decode(input logic [31:0] d,
                                                     input int unsigned w);
        logic        [63:0] mask_v;
        logic signed [63:0] val_v;
        mask_v = (64'd1 << w) - 64'd1;
        val_v  = $signed({32'd0, d} & mask_v) - $signed(64'd1 << (w - 1));
        return val_v[31:0];
    endfunction

    // Optional ReLU followed by optional clamp to a signed w-bit range.
    // With ReLU the lower clamp bound becomes 0. Without saturation the
    // caller keeps only the low w bits (plain truncation).
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                  input int unsigned       w,
                                                  input logic              relu,
                                                  input logic              sat);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = $signed((64'd1 << (w - 1)) - 64'd1);
        if (relu) begin
            lo = 64'sd0;
        end else begin
            lo = -$signed(64'd1 << (w - 1));
        end
        r = v;
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end else begin
            r = r;
        end
        if (sat) begin
            if (r > hi) begin
                r = hi;
            end else if (r < lo) begin
                r = lo;
            end else begin
                r = r;
            end
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/dnn_mac_lane.sv
// One MAC lane: accumulates activation*weight products for one output,
// then on the bias datum requantises, applies ReLU / saturation and
// registers the lane result.
module dnn_mac_lane
    import dnn_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int ACC_W      = 32,
    parameter int WT_W       = 8,
    parameter int FRAC_SHIFT = 8,
    parameter int RELU_ON    = 1,
    parameter int SATURATE   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    is_first,
    input  logic                    is_bias,
    input  logic signed [IN_W-1:0]  operand,
    input  logic signed [WT_W-1:0]  weight,
    output logic signed [OUT_W-1:0] res
);

    localparam int PW = IN_W + WT_W;

    logic signed [PW-1:0]    op_x_s;
    logic signed [PW-1:0]    wt_x_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] acc_base_s;
    logic signed [ACC_W-1:0] shifted_s;
    logic signed [63:0]      requant_s;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [OUT_W-1:0] res_r;

    // Full-precision product, accumulator restart and requantised sum.
    always_comb begin
        op_x_s     = PW'(operand);
        wt_x_s     = PW'(weight);
        prod_s     = op_x_s * wt_x_s;
        prod_ext_s = ACC_W'(prod_s);
        if (is_first) begin
            acc_base_s = {ACC_W{1'b0}};
        end else begin
            acc_base_s = acc_r;
        end
        shifted_s = acc_r >>> FRAC_SHIFT;
        requant_s = 64'(shifted_s) + 64'(weight);
    end

    // Accumulate on weight data; latch the finished output on the bias datum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
            res_r <= {OUT_W{1'b0}};
        end else if (en && !is_bias) begin
            acc_r <= acc_base_s + prod_ext_s;
        end else if (en && is_bias) begin
            res_r <= OUT_W'(sat_to(requant_s, OUT_W, (RELU_ON != 0), (SATURATE != 0)));
        end
    end

    assign res = res_r;

endmodule

// File: rtl/dense_layer_par.sv
// Parallel dense layer: streams weights for LANES outputs per ROM word,
// tags every read so returning data can be steered to the lanes, and
// collects lane results into the output register file.
module dense_layer_par
    import dnn_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int ACC_W      = 32,
    parameter int WT_W       = 8,
    parameter int N          = 64,
    parameter int M          = 32,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_LAT    = 1,
    parameter int FRAC_SHIFT = 8,
    parameter int RELU_ON    = 1,
    parameter int SATURATE   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  in [N],
    output logic                    busy,
    output logic                    done,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [LANES*WT_W-1:0]   mem_dout,
    output logic signed [OUT_W-1:0] out [M]
);

    localparam int G = M / LANES;
    localparam logic [TAG_FIELD_W-1:0] IDX_LAST  = TAG_FIELD_W'(N);
    localparam logic [TAG_FIELD_W-1:0] GRP_LAST  = TAG_FIELD_W'(G - 1);
    localparam logic [ADDR_WIDTH-1:0]  N_A       = ADDR_WIDTH'(N);
    localparam logic [ADDR_WIDTH-1:0]  BIAS_BASE = ADDR_WIDTH'(G * N);

    if ((M % LANES) != 0) begin : g_bad_lanes
        $error("dense_layer_par: M must be a multiple of LANES");
    end
    if (MEM_LAT < 1) begin : g_bad_lat
        $error("dense_layer_par: MEM_LAT must be at least 1");
    end
    if ((G * (N + 1)) > (1 << ADDR_WIDTH)) begin : g_bad_addr
        $error("dense_layer_par: ADDR_WIDTH too small for the ROM map");
    end

    state_t                  state_r;
    state_t                  state_nx;
    logic                    accept_s;
    logic                    issue_nx_s;
    logic                    last_addr_s;
    logic [TAG_FIELD_W-1:0]  nidx_s;
    logic [TAG_FIELD_W-1:0]  ngrp_s;
    logic [ADDR_WIDTH-1:0]   naddr_s;

    // tag_r[0] travels with the address being presented; tag_r[MEM_LAT]
    // lines up with the ROM word currently on mem_dout.
    tag_t                    tag_r [MEM_LAT+1];
    tag_t                    tc_s;

    logic                    busy_r;
    logic                    done_r;
    logic                    mem_en_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic signed [IN_W-1:0]  in_cap_r [N];
    logic signed [IN_W-1:0]  op_s;
    logic signed [WT_W-1:0]  w_s [LANES];
    logic signed [OUT_W-1:0] lane_res_s [LANES];
    logic                    wb_valid_r;
    logic                    wb_last_r;
    logic [TAG_FIELD_W-1:0]  wb_grp_r;
    logic signed [OUT_W-1:0] out_r [M];

    assign tc_s        = tag_r[MEM_LAT];
    assign last_addr_s = (tag_r[0].idx == IDX_LAST) && (tag_r[0].grp == GRP_LAST);

    // Control FSM: next state, start acceptance and read-issue decision.
    always_comb begin
        state_nx   = state_r;
        accept_s   = 1'b0;
        issue_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx   = ISSUE;
                    accept_s   = 1'b1;
                    issue_nx_s = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: begin
                if (last_addr_s) begin
                    state_nx = DRAIN;
                end else begin
                    issue_nx_s = 1'b1;
                end
            end
            DRAIN: begin
                if (wb_valid_r && wb_last_r) begin
                    state_nx = DONE;
                end else begin
                    state_nx = DRAIN;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Next read position (N weights then the bias per group) and its address.
    always_comb begin
        nidx_s = {TAG_FIELD_W{1'b0}};
        ngrp_s = {TAG_FIELD_W{1'b0}};
        if (accept_s) begin
            nidx_s = {TAG_FIELD_W{1'b0}};
            ngrp_s = {TAG_FIELD_W{1'b0}};
        end else if (issue_nx_s) begin
            if (tag_r[0].idx == IDX_LAST) begin
                nidx_s = {TAG_FIELD_W{1'b0}};
                ngrp_s = tag_r[0].grp + 16'd1;
            end else begin
                nidx_s = tag_r[0].idx + 16'd1;
                ngrp_s = tag_r[0].grp;
            end
        end else begin
            nidx_s = {TAG_FIELD_W{1'b0}};
            ngrp_s = {TAG_FIELD_W{1'b0}};
        end
        if (nidx_s == IDX_LAST) begin
            naddr_s = BIAS_BASE + ADDR_WIDTH'(ngrp_s);
        end else begin
            naddr_s = (ADDR_WIDTH'(ngrp_s) * N_A) + ADDR_WIDTH'(nidx_s);
        end
    end

    // State register and registered handshake / ROM interface outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mem_en_r   <= 1'b0;
            mem_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nx;
            busy_r     <= (state_nx == ISSUE) || (state_nx == DRAIN);
            done_r     <= (state_nx == DONE);
            mem_en_r   <= issue_nx_s;
            mem_addr_r <= issue_nx_s ? naddr_s : {ADDR_WIDTH{1'b0}};
        end
    end

    // Tag pipeline that follows each read through the ROM latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j <= MEM_LAT; j++) begin
                tag_r[j] <= tag_t'({TAG_W{1'b0}});
            end
        end else begin
            tag_r[0] <= {issue_nx_s, (nidx_s == IDX_LAST), nidx_s, ngrp_s};
            for (int j = 1; j <= MEM_LAT; j++) begin
                tag_r[j] <= tag_r[j-1];
            end
        end
    end

    // Snapshot of the activations taken only when a start is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                in_cap_r[k] <= {IN_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                in_cap_r[k] <= accept_s ? in[k] : in_cap_r[k];
            end
        end
    end

    // Activation selected by the returning tag (zero for bias words).
    always_comb begin
        op_s = {IN_W{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (tc_s.idx == TAG_FIELD_W'(k)) begin
                op_s = in_cap_r[k];
            end else begin
                op_s = op_s;
            end
        end
    end

    // Decode each lane's slice of the ROM word.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_s[l] = WT_W'(wt_decode(32'(mem_dout[l*WT_W +: WT_W]), WT_W));
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dnn_mac_lane #(
            .IN_W       (IN_W),
            .OUT_W      (OUT_W),
            .ACC_W      (ACC_W),
            .WT_W       (WT_W),
            .FRAC_SHIFT (FRAC_SHIFT),
            .RELU_ON    (RELU_ON),
            .SATURATE   (SATURATE)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (tc_s.valid),
            .is_first (tc_s.idx == {TAG_FIELD_W{1'b0}}),
            .is_bias  (tc_s.is_bias),
            .operand  (op_s),
            .weight   (w_s[l]),
            .res      (lane_res_s[l])
        );
    end

    // Remember which group the lanes just finished so it can be written back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_r <= 1'b0;
            wb_last_r  <= 1'b0;
            wb_grp_r   <= {TAG_FIELD_W{1'b0}};
        end else begin
            wb_valid_r <= tc_s.valid && tc_s.is_bias;
            wb_last_r  <= (tc_s.grp == GRP_LAST);
            wb_grp_r   <= tc_s.grp;
        end
    end

    // Output register file: one group of LANES entries written per bias datum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int m = 0; m < M; m++) begin
                out_r[m] <= {OUT_W{1'b0}};
            end
        end else begin
            for (int g = 0; g < G; g++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wb_valid_r && (wb_grp_r == TAG_FIELD_W'(g))) begin
                        out_r[g*LANES + l] <= lane_res_s[l];
                    end
                end
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign mem_en   = mem_en_r;
    assign mem_addr = mem_addr_r;
    assign out      = out_r;

endmodule

// File: tb/tb_dense_layer_par.sv
// Bench for dense_layer_par: a default-size instance (MEM_LAT=1, ReLU and
// saturation on) and a small instance (MEM_LAT=3, FRAC_SHIFT=0, no ReLU,
// truncation), each fed by a behavioural ROM built from the weight map.
module tb_dense_layer_par;

    localparam int A_N = 64, A_M = 32, A_L = 4, A_LAT = 1;
    localparam int B_N = 4,  B_M = 4,  B_L = 2, B_LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               a_start, a_busy, a_done, a_mem_en;
    logic [11:0]        a_mem_addr;
    logic [31:0]        a_mem_dout;
    logic signed [15:0] a_in  [A_N];
    logic signed [15:0] a_out [A_M];

    logic               b_start, b_busy, b_done, b_mem_en;
    logic [11:0]        b_mem_addr;
    logic [15:0]        b_mem_dout;
    logic signed [15:0] b_in  [B_N];
    logic signed [15:0] b_out [B_M];
    logic [15:0]        b_pipe [B_LAT];

    dense_layer_par #(.N(A_N), .M(A_M), .LANES(A_L), .MEM_LAT(A_LAT)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in(a_in), .busy(a_busy),
        .done(a_done), .mem_en(a_mem_en), .mem_addr(a_mem_addr),
        .mem_dout(a_mem_dout), .out(a_out)
    );

    dense_layer_par #(.N(B_N), .M(B_M), .LANES(B_L), .MEM_LAT(B_LAT),
                      .FRAC_SHIFT(0), .RELU_ON(0), .SATURATE(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in(b_in), .busy(b_busy),
        .done(b_done), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
        .mem_dout(b_mem_dout), .out(b_out)
    );

    int     rom_mode = 0, rom_wc = 0, rom_bc = 0;
    int     x [64];
    int     n_pass = 0, n_total = 0;
    longint qa[$];
    longint qb[$];

    // mode 0: every weight wc, every bias bc; mode 1: position-dependent pattern
    function automatic int wval(input int mode, input int wc, input int m, input int i);
        if (mode == 0) return wc;
        return ((m * 3 + i * 5) % 15) - 7;
    endfunction

    function automatic int bval(input int mode, input int bc, input int m);
        if (mode == 0) return bc;
        return (m % 7) - 3;
    endfunction

    function automatic logic [31:0] rom_word(input int n, input int lanes, input int grps,
                                             input int mode, input int wc, input int bc,
                                             input int addr);
        logic [31:0] w;
        int g, i, v;
        w = 32'd0;
        for (int l = 0; l < lanes; l++) begin
            if (addr < grps * n) begin
                g = addr / n;
                i = addr % n;
                v = wval(mode, wc, g * lanes + l, i);
            end else begin
                g = addr - grps * n;
                v = bval(mode, bc, g * lanes + l);
            end
            w[l*8 +: 8] = 8'(v + 128);
        end
        return w;
    endfunction

    function automatic longint model(input int m, input int n, input int fs, input bit relu,
                                     input bit sat, input int mode, input int wc, input int bc,
                                     input int xin [64]);
        longint acc, r;
        acc = 0;
        for (int i = 0; i < n; i++) acc += longint'(xin[i]) * longint'(wval(mode, wc, m, i));
        r = (acc >>> fs) + longint'(bval(mode, bc, m));
        if (relu && r < 0) r = 0;
        if (sat) begin
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
        end else begin
            r = r & 64'hFFFF;
            if (r > 32767) r -= 65536;
        end
        return r;
    endfunction

    // ROM for instance A: one-cycle synchronous read
    always @(posedge clk)
        a_mem_dout <= rom_word(A_N, A_L, A_M / A_L, rom_mode, rom_wc, rom_bc, int'(a_mem_addr));

    // ROM for instance B: three-stage pipelined read
    always @(posedge clk) begin
        b_pipe[0] <= 16'(rom_word(B_N, B_L, B_M / B_L, rom_mode, rom_wc, rom_bc, int'(b_mem_addr)));
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_mem_dout = b_pipe[B_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic run_a(input string tag, input bit hold_start, input bit perturb);
        int cnt;
        for (int i = 0; i < A_N; i++) a_in[i] = 16'(x[i]);
        for (int m = 0; m < A_M; m++)
            qa.push_back(model(m, A_N, 8, 1'b1, 1'b1, rom_mode, rom_wc, rom_bc, x));
        a_start = 1'b1;
        tick();
        if (!hold_start) a_start = 1'b0;
        chk({tag, "_busy_after_accept"}, a_busy, 1);
        cnt = 0;
        while (a_done !== 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
            if (perturb && cnt == 5)
                for (int i = 0; i < A_N; i++) a_in[i] = 16'(7 - x[i]);
        end
        a_start = 1'b0;
        chk({tag, "_latency"}, cnt, (A_M / A_L) * (A_N + 1) + A_LAT + 1);
        chk({tag, "_busy_at_done"}, a_busy, 0);
        chk({tag, "_mem_en_idle"}, a_mem_en, 0);
        chk({tag, "_mem_addr_idle"}, a_mem_addr, 0);
        for (int m = 0; m < A_M; m++)
            chk($sformatf("%s_out%0d", tag, m), a_out[m], qa.pop_front());
        tick();
        chk({tag, "_done_single"}, a_done, 0);
        chk({tag, "_no_restart"}, a_busy, 0);
    endtask

    task automatic run_b(input string tag);
        int cnt;
        for (int i = 0; i < B_N; i++) b_in[i] = 16'(x[i]);
        for (int m = 0; m < B_M; m++)
            qb.push_back(model(m, B_N, 0, 1'b0, 1'b0, rom_mode, rom_wc, rom_bc, x));
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk({tag, "_busy_after_accept"}, b_busy, 1);
        cnt = 0;
        while (b_done !== 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, cnt, (B_M / B_L) * (B_N + 1) + B_LAT + 1);
        chk({tag, "_mem_en_idle"}, b_mem_en, 0);
        for (int m = 0; m < B_M; m++)
            chk($sformatf("%s_out%0d", tag, m), b_out[m], qb.pop_front());
        tick();
        chk({tag, "_done_single"}, b_done, 0);
    endtask

    task automatic fill_x(input int v);
        for (int i = 0; i < 64; i++) x[i] = v;
    endtask

    initial begin
        int nz, dn;
        rst_n = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        for (int i = 0; i < A_N; i++) a_in[i] = 16'sd0;
        for (int i = 0; i < B_N; i++) b_in[i] = 16'sd0;
        fill_x(0);
        repeat (3) tick();
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_mem_en", a_mem_en, 0);
        chk("rst_a_mem_addr", a_mem_addr, 0);
        chk("rst_a_out0", a_out[0], 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_out3", b_out[3], 0);
        rst_n = 1'b1;
        tick();

        // small instance: unit weights, unit inputs -> 4
        rom_mode = 0; rom_wc = 1; rom_bc = 0; fill_x(1);
        run_b("t1");
        chk("t1_const", b_out[0], 4);

        // negative sum without ReLU, FRAC_SHIFT=0
        rom_wc = 1; rom_bc = 0; fill_x(-256);
        run_b("t3b");
        chk("t3b_const", b_out[1], -1024);

        // overflow with truncation
        rom_wc = 127; rom_bc = 0; fill_x(32767);
        run_b("t4b");

        // varied weights/biases on the pipelined ROM
        rom_mode = 1;
        for (int i = 0; i < 64; i++) x[i] = ((i * 397) % 4001) - 2000;
        run_b("pat_b");

        // default instance: requant + bias
        rom_mode = 0; rom_wc = 2; rom_bc = -3; fill_x(256);
        run_a("t2", 1'b0, 1'b0);
        chk("t2_const", a_out[31], 125);

        // negative sum clamped by ReLU
        rom_wc = 1; rom_bc = 0; fill_x(-256);
        run_a("t3", 1'b0, 1'b0);
        chk("t3_const", a_out[5], 0);

        // overflow saturates
        rom_wc = 127; rom_bc = 0; fill_x(32767);
        run_a("t4", 1'b0, 1'b0);
        chk("t4_const", a_out[17], 32767);

        // position-dependent weights exercise lane/group mapping
        rom_mode = 1;
        for (int i = 0; i < 64; i++) x[i] = ((i * 397) % 4001) - 2000;
        run_a("pat_a", 1'b0, 1'b0);

        // start held high and inputs changed mid-run
        rom_mode = 0; rom_wc = 2; rom_bc = -3; fill_x(256);
        run_a("t5", 1'b1, 1'b1);

        // reset in the middle of ISSUE
        for (int i = 0; i < A_N; i++) a_in[i] = 16'(x[i]);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (10) tick();
        chk("t6_busy_midrun", a_busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_busy_after_rst", a_busy, 0);
        chk("t6_mem_en_after_rst", a_mem_en, 0);
        nz = 0;
        for (int m = 0; m < A_M; m++) if (a_out[m] !== 16'sd0) nz++;
        chk("t6_out_cleared", nz, 0);
        dn = 0;
        repeat (600) begin
            tick();
            if (a_done === 1'b1) dn++;
        end
        chk("t6_no_done", dn, 0);
        run_a("t6_rerun", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
